// File: rtl/process_scheduler_pkg.sv
// Shared definitions for the round-robin process scheduler: default sizing
// and the scheduler state encoding.
package process_scheduler_pkg;

    localparam int NUM_PROC_DEF = 8;
    localparam int PID_W_DEF    = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PICK  = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_SAVE  = 3'd5
    } state_t;

endpackage

// File: rtl/process_scheduler_rr_picker.sv
// Combinational round-robin picker: finds the first ready slot after base,
// wrapping around, with base itself considered last.
module process_scheduler_rr_picker
    import process_scheduler_pkg::*;
#(
    parameter int NUM_PROC = NUM_PROC_DEF,
    parameter int PID_W    = PID_W_DEF
) (
    input  logic [NUM_PROC-1:0] ready,
    input  logic [PID_W-1:0]    base,
    output logic                hit,
    output logic [PID_W-1:0]    pid
);

    logic [NUM_PROC-1:0] rot;
    logic [PID_W-1:0]    idx;

    // Rotate so that bit 0 is slot base+1; the last bit wraps back to base.
    generate
        for (genvar gi = 0; gi < NUM_PROC; gi++) begin : g_rot
            assign rot[gi] = ready[base + PID_W'(gi + 1)];
        end
    endgenerate

    // Priority-encode the lowest set bit of the rotated vector.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                hit = 1'b1;
                idx = PID_W'(i);
            end
        end
    end

    // Un-rotate back to an absolute PID (modulo NUM_PROC by truncation).
    assign pid = base + idx + PID_W'(1);

endmodule

// File: rtl/process_scheduler.sv
// Round-robin process scheduler: keeps the ready/blocked table, sequences
// save/load context switches and drives the quantum timer control pulses.
module process_scheduler
    import process_scheduler_pkg::*;
#(
    parameter int NUM_PROC = NUM_PROC_DEF,
    parameter int PID_W    = PID_W_DEF
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Spawn,
    input  logic [PID_W-1:0] SpawnPID,
    input  logic             Finalize,
    input  logic             IOBlock,
    input  logic             IODone,
    input  logic [PID_W-1:0] IODonePID,
    input  logic             OutOfQuantum,
    input  logic             SaveAck,
    input  logic             LoadAck,
    output logic             SaveReq,
    output logic             LoadReq,
    output logic [PID_W-1:0] CurrentPID,
    output logic [PID_W-1:0] NextPID,
    output logic             Running,
    output logic             PREEMP_ON,
    output logic             PREEMP_OFF
);

    state_t              state_reg, state_next;
    logic [PID_W-1:0]    cur_pid_reg, cur_pid_next;
    logic [PID_W-1:0]    next_pid_reg, next_pid_next;
    logic [NUM_PROC-1:0] ready_reg, ready_next;
    logic [NUM_PROC-1:0] blocked_reg, blocked_next;
    logic                preemp_off_reg, preemp_off_next;

    logic                pick_hit;
    logic [PID_W-1:0]    pick_pid;

    process_scheduler_rr_picker #(
        .NUM_PROC (NUM_PROC),
        .PID_W    (PID_W)
    ) u_picker (
        .ready (ready_reg),
        .base  (cur_pid_reg),
        .hit   (pick_hit),
        .pid   (pick_pid)
    );

    // Register all scheduler state; reset overrides every input.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg      <= S_IDLE;
            cur_pid_reg    <= '0;
            next_pid_reg   <= '0;
            ready_reg      <= '0;
            blocked_reg    <= '0;
            preemp_off_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cur_pid_reg    <= cur_pid_next;
            next_pid_reg   <= next_pid_next;
            ready_reg      <= ready_next;
            blocked_reg    <= blocked_next;
            preemp_off_reg <= preemp_off_next;
        end
    end

    // Next-state logic; RUN events are resolved Finalize > IOBlock > quantum > disable.
    always_comb begin
        state_next      = state_reg;
        cur_pid_next    = cur_pid_reg;
        next_pid_next   = next_pid_reg;
        preemp_off_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (Enable && (|ready_reg)) state_next = S_PICK;
            end
            S_PICK: begin
                if (Enable && pick_hit) begin
                    next_pid_next = pick_pid;
                    state_next    = S_LOAD;
                end else begin
                    preemp_off_next = 1'b1;
                    state_next      = S_IDLE;
                end
            end
            S_LOAD: begin
                if (LoadAck) begin
                    cur_pid_next = next_pid_reg;
                    state_next   = S_START;
                end
            end
            S_START: state_next = S_RUN;
            S_RUN: begin
                if (Finalize)          state_next = S_PICK;
                else if (IOBlock)      state_next = S_SAVE;
                else if (OutOfQuantum) state_next = S_SAVE;
                else if (!Enable)      state_next = S_SAVE;
            end
            S_SAVE: begin
                if (SaveAck) begin
                    if (Enable) begin
                        state_next = S_PICK;
                    end else begin
                        preemp_off_next = 1'b1;
                        state_next      = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Ready/blocked table: clears from the running process first, sets applied last so they win.
    always_comb begin
        ready_next   = ready_reg;
        blocked_next = blocked_reg;
        if (state_reg == S_RUN) begin
            if (Finalize) begin
                ready_next[cur_pid_reg] = 1'b0;
            end else if (IOBlock) begin
                ready_next[cur_pid_reg]   = 1'b0;
                blocked_next[cur_pid_reg] = 1'b1;
            end
        end
        if (IODone && blocked_reg[IODonePID]) begin
            blocked_next[IODonePID] = 1'b0;
            ready_next[IODonePID]   = 1'b1;
        end
        if (Spawn) begin
            ready_next[SpawnPID]   = 1'b1;
            blocked_next[SpawnPID] = 1'b0;
        end
    end

    assign SaveReq    = (state_reg == S_SAVE);
    assign LoadReq    = (state_reg == S_LOAD);
    assign Running    = (state_reg == S_RUN);
    assign PREEMP_ON  = (state_reg == S_START);
    assign PREEMP_OFF = preemp_off_reg;
    assign CurrentPID = cur_pid_reg;
    assign NextPID    = next_pid_reg;

endmodule

// File: tb/tb_process_scheduler.sv
// Directed testbench for the round-robin process scheduler.
module tb_process_scheduler;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic       Enable = 1'b0;
    logic       Spawn = 1'b0;
    logic [2:0] SpawnPID = 3'd0;
    logic       Finalize = 1'b0;
    logic       IOBlock = 1'b0;
    logic       IODone = 1'b0;
    logic [2:0] IODonePID = 3'd0;
    logic       OutOfQuantum = 1'b0;
    logic       SaveAck = 1'b0;
    logic       LoadAck = 1'b0;
    logic       SaveReq, LoadReq, Running, PREEMP_ON, PREEMP_OFF;
    logic [2:0] CurrentPID, NextPID;

    int total = 0;
    int bad   = 0;

    process_scheduler #(.NUM_PROC(8), .PID_W(3)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Enable       (Enable),
        .Spawn        (Spawn),
        .SpawnPID     (SpawnPID),
        .Finalize     (Finalize),
        .IOBlock      (IOBlock),
        .IODone       (IODone),
        .IODonePID    (IODonePID),
        .OutOfQuantum (OutOfQuantum),
        .SaveAck      (SaveAck),
        .LoadAck      (LoadAck),
        .SaveReq      (SaveReq),
        .LoadReq      (LoadReq),
        .CurrentPID   (CurrentPID),
        .NextPID      (NextPID),
        .Running      (Running),
        .PREEMP_ON    (PREEMP_ON),
        .PREEMP_OFF   (PREEMP_OFF)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        total++;
        if ({SaveReq, LoadReq, Running, PREEMP_ON, PREEMP_OFF} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {SaveReq, LoadReq, Running, PREEMP_ON, PREEMP_OFF});
        end
        total++;
        if ({CurrentPID, NextPID} !== 6'd0) begin
            bad++;
            $display("FAIL reset_pids got=%0d/%0d exp=0/0", CurrentPID, NextPID);
        end
        total++;
        if (dut.ready_reg !== 8'h00) begin
            bad++;
            $display("FAIL reset_ready got=%h exp=00", dut.ready_reg);
        end
        $display("test_reset done");
    endtask

    task automatic test_first_dispatch;
        Spawn = 1'b1; SpawnPID = 3'd2;
        tick();
        SpawnPID = 3'd5;
        tick();
        Spawn = 1'b0;
        total++;
        if (dut.ready_reg !== 8'h24) begin
            bad++;
            $display("FAIL spawn_ready got=%h exp=24", dut.ready_reg);
        end
        Enable = 1'b1;
        tick();                     // PICK
        tick();                     // LOAD
        total++;
        if (LoadReq !== 1'b1 || NextPID !== 3'd2) begin
            bad++;
            $display("FAIL first_load got=%b/%0d exp=1/2", LoadReq, NextPID);
        end
        tick();                     // still LOAD, no ack
        total++;
        if (LoadReq !== 1'b1) begin
            bad++;
            $display("FAIL load_hold got=%b exp=1", LoadReq);
        end
        LoadAck = 1'b1;
        tick();                     // START
        total++;
        if (PREEMP_ON !== 1'b1 || CurrentPID !== 3'd2 || LoadReq !== 1'b0) begin
            bad++;
            $display("FAIL first_start got=on%b cur%0d ld%b exp=on1 cur2 ld0",
                     PREEMP_ON, CurrentPID, LoadReq);
        end
        LoadAck = 1'b0;
        tick();                     // RUN
        total++;
        if (Running !== 1'b1 || PREEMP_ON !== 1'b0) begin
            bad++;
            $display("FAIL first_run got=run%b on%b exp=run1 on0", Running, PREEMP_ON);
        end
        $display("test_first_dispatch done");
    endtask

    task automatic test_quantum;
        OutOfQuantum = 1'b1;
        tick();                     // SAVE
        OutOfQuantum = 1'b0;
        total++;
        if (SaveReq !== 1'b1 || Running !== 1'b0) begin
            bad++;
            $display("FAIL quantum_save got=sv%b run%b exp=sv1 run0", SaveReq, Running);
        end
        SaveAck = 1'b1;
        tick();                     // PICK
        SaveAck = 1'b0;
        tick();                     // LOAD
        total++;
        if (NextPID !== 3'd5 || LoadReq !== 1'b1) begin
            bad++;
            $display("FAIL quantum_next got=%0d/%b exp=5/1", NextPID, LoadReq);
        end
        LoadAck = 1'b1;
        tick();                     // START
        LoadAck = 1'b0;
        total++;
        if (CurrentPID !== 3'd5) begin
            bad++;
            $display("FAIL quantum_cur got=%0d exp=5", CurrentPID);
        end
        tick();                     // RUN
        $display("test_quantum done");
    endtask

    task automatic test_wrap_latency;
        SaveAck = 1'b1;
        LoadAck = 1'b1;
        OutOfQuantum = 1'b1;
        tick();                     // SAVE (1)
        OutOfQuantum = 1'b0;
        tick();                     // PICK (2)
        tick();                     // LOAD (3)
        total++;
        if (PREEMP_ON !== 1'b0) begin
            bad++;
            $display("FAIL latency_early got=%b exp=0", PREEMP_ON);
        end
        tick();                     // START (4)
        total++;
        if (PREEMP_ON !== 1'b1 || CurrentPID !== 3'd2) begin
            bad++;
            $display("FAIL latency_wrap got=on%b cur%0d exp=on1 cur2", PREEMP_ON, CurrentPID);
        end
        tick();                     // RUN
        $display("test_wrap_latency done");
    endtask

    task automatic test_ioblock;
        // acks still high: switch 2 -> 5
        OutOfQuantum = 1'b1;
        tick();
        OutOfQuantum = 1'b0;
        tick();
        tick();
        tick();
        tick();                     // RUN on 5
        total++;
        if (CurrentPID !== 3'd5 || Running !== 1'b1) begin
            bad++;
            $display("FAIL io_pre got=cur%0d run%b exp=cur5 run1", CurrentPID, Running);
        end
        IOBlock = 1'b1;
        tick();                     // SAVE
        IOBlock = 1'b0;
        total++;
        if (dut.ready_reg !== 8'h04 || dut.blocked_reg !== 8'h20 || SaveReq !== 1'b1) begin
            bad++;
            $display("FAIL io_block got=r%h b%h sv%b exp=r04 b20 sv1",
                     dut.ready_reg, dut.blocked_reg, SaveReq);
        end
        tick();                     // PICK
        tick();                     // LOAD
        total++;
        if (NextPID !== 3'd2) begin
            bad++;
            $display("FAIL io_next got=%0d exp=2", NextPID);
        end
        tick();                     // START
        tick();                     // RUN
        SaveAck = 1'b0;
        LoadAck = 1'b0;
        total++;
        if (CurrentPID !== 3'd2 || Running !== 1'b1) begin
            bad++;
            $display("FAIL io_run2 got=cur%0d run%b exp=cur2 run1", CurrentPID, Running);
        end
        IODone = 1'b1; IODonePID = 3'd5;
        tick();
        total++;
        if (dut.ready_reg !== 8'h24 || dut.blocked_reg !== 8'h00) begin
            bad++;
            $display("FAIL iodone5 got=r%h b%h exp=r24 b00", dut.ready_reg, dut.blocked_reg);
        end
        IODonePID = 3'd3;
        tick();
        IODone = 1'b0;
        total++;
        if (dut.ready_reg !== 8'h24 || dut.blocked_reg !== 8'h00) begin
            bad++;
            $display("FAIL iodone3 got=r%h b%h exp=r24 b00", dut.ready_reg, dut.blocked_reg);
        end
        $display("test_ioblock done");
    endtask

    task automatic test_finalize_priority;
        Finalize = 1'b1;
        OutOfQuantum = 1'b1;
        tick();                     // PICK via Finalize
        Finalize = 1'b0;
        OutOfQuantum = 1'b0;
        total++;
        if (SaveReq !== 1'b0 || Running !== 1'b0 || dut.ready_reg !== 8'h20) begin
            bad++;
            $display("FAIL fin_prio got=sv%b run%b r%h exp=sv0 run0 r20",
                     SaveReq, Running, dut.ready_reg);
        end
        tick();                     // LOAD
        total++;
        if (NextPID !== 3'd5) begin
            bad++;
            $display("FAIL fin_next got=%0d exp=5", NextPID);
        end
        LoadAck = 1'b1;
        tick();                     // START
        LoadAck = 1'b0;
        tick();                     // RUN on 5
        $display("test_finalize_priority done");
    endtask

    task automatic test_spawn_finalize;
        Spawn = 1'b1; SpawnPID = 3'd5;
        Finalize = 1'b1;
        tick();                     // PICK
        Spawn = 1'b0;
        Finalize = 1'b0;
        total++;
        if (dut.ready_reg !== 8'h20 || SaveReq !== 1'b0) begin
            bad++;
            $display("FAIL spawn_fin got=r%h sv%b exp=r20 sv0", dut.ready_reg, SaveReq);
        end
        tick();                     // LOAD, lone process reselected
        total++;
        if (NextPID !== 3'd5 || LoadReq !== 1'b1) begin
            bad++;
            $display("FAIL lone_reselect got=%0d/%b exp=5/1", NextPID, LoadReq);
        end
        LoadAck = 1'b1;
        tick();
        LoadAck = 1'b0;
        tick();                     // RUN on 5
        $display("test_spawn_finalize done");
    endtask

    task automatic test_pick_miss;
        Finalize = 1'b1;
        tick();                     // PICK with empty table
        Finalize = 1'b0;
        total++;
        if (SaveReq !== 1'b0 || dut.ready_reg !== 8'h00) begin
            bad++;
            $display("FAIL miss_pick got=sv%b r%h exp=sv0 r00", SaveReq, dut.ready_reg);
        end
        tick();                     // IDLE
        total++;
        if (PREEMP_OFF !== 1'b1 || Running !== 1'b0 || LoadReq !== 1'b0) begin
            bad++;
            $display("FAIL miss_off got=off%b run%b ld%b exp=off1 run0 ld0",
                     PREEMP_OFF, Running, LoadReq);
        end
        tick();
        total++;
        if (PREEMP_OFF !== 1'b0 || LoadReq !== 1'b0) begin
            bad++;
            $display("FAIL miss_pulse got=off%b ld%b exp=off0 ld0", PREEMP_OFF, LoadReq);
        end
        $display("test_pick_miss done");
    endtask

    task automatic test_disable;
        Spawn = 1'b1; SpawnPID = 3'd3;
        tick();                     // still IDLE, ready updated
        Spawn = 1'b0;
        LoadAck = 1'b1;
        tick();                     // PICK
        tick();                     // LOAD
        total++;
        if (NextPID !== 3'd3) begin
            bad++;
            $display("FAIL dis_next got=%0d exp=3", NextPID);
        end
        tick();                     // START
        tick();                     // RUN
        LoadAck = 1'b0;
        Enable = 1'b0;
        SaveAck = 1'b1;
        tick();                     // SAVE
        total++;
        if (SaveReq !== 1'b1) begin
            bad++;
            $display("FAIL dis_save got=%b exp=1", SaveReq);
        end
        tick();                     // IDLE
        SaveAck = 1'b0;
        total++;
        if (PREEMP_OFF !== 1'b1 || Running !== 1'b0 || dut.ready_reg !== 8'h08) begin
            bad++;
            $display("FAIL dis_idle got=off%b run%b r%h exp=off1 run0 r08",
                     PREEMP_OFF, Running, dut.ready_reg);
        end
        $display("test_disable done");
    endtask

    task automatic test_reset_in_load;
        Spawn = 1'b1; SpawnPID = 3'd1;
        Enable = 1'b1;
        tick();                     // PICK
        Spawn = 1'b0;
        tick();                     // LOAD
        total++;
        if (LoadReq !== 1'b1 || NextPID !== 3'd1) begin
            bad++;
            $display("FAIL rl_load got=%b/%0d exp=1/1", LoadReq, NextPID);
        end
        Reset = 1'b1;
        LoadAck = 1'b1;
        tick();
        total++;
        if (LoadReq !== 1'b0 || PREEMP_ON !== 1'b0 || dut.ready_reg !== 8'h00 ||
            CurrentPID !== 3'd0) begin
            bad++;
            $display("FAIL rl_reset got=ld%b on%b r%h cur%0d exp=ld0 on0 r00 cur0",
                     LoadReq, PREEMP_ON, dut.ready_reg, CurrentPID);
        end
        Reset = 1'b0;
        LoadAck = 1'b0;
        Enable = 1'b0;
        tick();
        $display("test_reset_in_load done");
    endtask

    initial begin
        test_reset();
        test_first_dispatch();
        test_quantum();
        test_wrap_latency();
        test_ioblock();
        test_finalize_priority();
        test_spawn_finalize();
        test_pick_miss();
        test_disable();
        test_reset_in_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
